// File: rtl/alu_muldiv.sv
// RV32M multiply/divide unit: two-cycle multiplier beside a radix-2 restoring divider,
// with valid/ready handshakes on both sides and a synchronous flush.
module alu_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   rem_q;
    logic [CW-1:0]  cnt_q;
    logic           q_neg_q;
    logic           r_neg_q;
    logic           valid_q;
    logic [W-1:0]   result_q;
    logic           zero_q;

    // Accept-time decode: signedness, magnitudes and the no-iteration special cases.
    logic           in_signed;
    logic           a_neg_in;
    logic           b_neg_in;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           div_by_zero;
    logic           div_overflow;
    logic           div_special;
    logic [W-1:0]   special_res;

    assign in_signed    = ~op[0];
    assign a_neg_in     = in_signed & op_a[W-1];
    assign b_neg_in     = in_signed & op_b[W-1];
    assign a_mag        = a_neg_in ? -op_a : op_a;
    assign b_mag        = b_neg_in ? -op_b : op_b;
    assign div_by_zero  = (op_b == '0);
    assign div_overflow = in_signed && (op_a == MOST_NEG) && (op_b == '1);
    assign div_special  = div_by_zero || div_overflow;

    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = op[1] ? op_a : '1;
        end else begin
            special_res = op[1] ? '0 : op_a;
        end
    end

    // Multiplier datapath: sign-extend to 2W so one unsigned product covers all four variants.
    logic           a_sgn_d;
    logic           b_sgn_d;
    logic [2*W-1:0] a_ext_d;
    logic [2*W-1:0] b_ext_d;
    logic [2*W-1:0] prod_d;
    logic [W-1:0]   mul_res_d;

    assign a_sgn_d   = (op_q != 2'b11);
    assign b_sgn_d   = ~op_q[1];
    assign a_ext_d   = {{W{a_sgn_d & a_q[W-1]}}, a_q};
    assign b_ext_d   = {{W{b_sgn_d & b_q[W-1]}}, b_q};
    assign prod_d    = a_ext_d * b_ext_d;
    assign mul_res_d = (op_q == 2'b00) ? prod_d[W-1:0] : prod_d[2*W-1:W];

    // Divider step: a_q shifts the dividend out while quotient bits shift in at the bottom.
    logic [W:0]     rem_sh_d;
    logic [W:0]     diff_d;
    logic           ge_d;
    logic [W-1:0]   rem_d;
    logic [W-1:0]   quo_d;
    logic [W-1:0]   q_fin_d;
    logic [W-1:0]   r_fin_d;
    logic [W-1:0]   div_res_d;

    assign rem_sh_d  = {rem_q, a_q[W-1]};
    assign diff_d    = rem_sh_d - {1'b0, b_q};
    assign ge_d      = ~diff_d[W];
    assign rem_d     = ge_d ? diff_d[W-1:0] : rem_sh_d[W-1:0];
    assign quo_d     = {a_q[W-2:0], ge_d};
    assign q_fin_d   = q_neg_q ? -quo_d : quo_d;
    assign r_fin_d   = r_neg_q ? -rem_d : rem_d;
    assign div_res_d = op_q[1] ? r_fin_d : q_fin_d;

    assign ready_in    = (state_q == S_IDLE) && !rst;
    assign valid_out   = valid_q;
    assign result      = result_q;
    assign result_zero = zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (flush) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        op_q <= op[1:0];
                        if (!op[2]) begin
                            a_q     <= op_a;
                            b_q     <= op_b;
                            state_q <= S_MUL;
                        end else if (div_special) begin
                            a_q      <= op_a;
                            b_q      <= op_b;
                            result_q <= special_res;
                            zero_q   <= (special_res == '0);
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            a_q     <= a_mag;
                            b_q     <= b_mag;
                            rem_q   <= '0;
                            cnt_q   <= CNT_INIT;
                            q_neg_q <= a_neg_in ^ b_neg_in;
                            r_neg_q <= a_neg_in;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    result_q <= mul_res_d;
                    zero_q   <= (mul_res_d == '0);
                    valid_q  <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DIV: begin
                    a_q   <= quo_d;
                    rem_q <= rem_d;
                    if (cnt_q == '0) begin
                        result_q <= div_res_d;
                        zero_q   <= (div_res_d == '0);
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (ready_out) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: a per-cycle reference model of the handshake and RV32M arithmetic,
// directed literal cases, then randomized traffic with flushes, resets and back-pressure.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         valid_in;
    logic         ready_in;
    logic [2:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         valid_out;
    logic         ready_out;
    logic [W-1:0] result;
    logic         result_zero;

    alu_muldiv #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .result      (result),
        .result_zero (result_zero)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // RV32M arithmetic straight from the ISA definitions, using 64-bit integers.
    function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = 64'(ua / ub); return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = 64'(ua % ub); return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return 2;
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Reference model state: busy flag, cycles left, pending and visible results.
    bit          m_pend  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    logic [31:0] m_exp   = '0;
    logic [31:0] m_res   = '0;

    // Compare every cycle at the falling edge, then advance the model for the coming rising edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("valid_out", valid_out, m_valid);
            check("ready_in", ready_in, (!m_pend && !rst));
            check("result", result, m_res);
            check("result_zero", result_zero, (m_res == 0));
            if (rst) begin
                m_pend = 0; m_valid = 0; m_res = '0;
            end else if (flush) begin
                m_pend = 0; m_valid = 0;
            end else if (m_valid) begin
                if (ready_out) begin m_valid = 0; m_pend = 0; end
            end else if (m_pend) begin
                m_wait--;
                if (m_wait == 0) begin m_valid = 1; m_res = m_exp; end
            end else if (valid_in) begin
                m_pend = 1;
                m_exp  = model_res(op, op_a, op_b);
                m_wait = model_lat(op, op_a, op_b) - 1;
                if (m_wait == 0) begin m_valid = 1; m_res = m_exp; end
            end
        end
    end

    // Issue one op from IDLE, measure latency, check the literal result; consume if ready_out is high.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        check("model_pin", model_res(o, a, b), exp);
        op = o; op_a = a; op_b = b; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; op_a = $urandom; op_b = $urandom;
        lat = 1;
        while (!valid_out && lat < 100) begin
            check("busy_ready_in", ready_in, 1'b0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("op_result", result, exp);
        check("op_result_zero", result_zero, (exp == 0));
        if (ready_out) begin
            @(posedge clk); #1;
            check("consumed_valid", valid_out, 1'b0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        op = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_zero", result_zero, 1'b1);
        check("rst_valid", valid_out, 1'b0);
        check("rst_ready_in", ready_in, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_ready_in", ready_in, 1'b1);
        @(posedge clk); #1;

        do_op(3'd0, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 2);
        do_op(3'd1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 2);
        do_op(3'd2, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 2);
        do_op(3'd3, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 2);
        do_op(3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
        do_op(3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
        do_op(3'd5, 32'hFFFF_FFF9, 32'h2, 32'h7FFF_FFFC, 33);
        do_op(3'd4, 32'h5, 32'h0, 32'hFFFF_FFFF, 1);
        do_op(3'd7, 32'h5, 32'h0, 32'h0000_0005, 1);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Consumer stall in DONE.
        ready_out = 1'b0;
        do_op(3'd0, 32'h7, 32'h6, 32'd42, 2);
        repeat (10) begin
            @(posedge clk); #1;
            check("stall_result", result, 32'd42);
            check("stall_valid", valid_out, 1'b1);
            check("stall_ready_in", ready_in, 1'b0);
        end
        ready_out = 1'b1;
        @(posedge clk); #1;
        check("release_ready_in", ready_in, 1'b1);
        check("release_valid", valid_out, 1'b0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);

        // Flush mid-divide, with valid_in raised at the same time.
        op = 3'd4; op_a = 32'd100; op_b = 32'd7; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        flush = 1'b1; valid_in = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        check("flush_ready_in", ready_in, 1'b1);
        check("flush_valid", valid_out, 1'b0);
        repeat (40) begin
            @(posedge clk); #1;
            check("flush_no_valid", valid_out, 1'b0);
        end
        // Flush in IDLE blocks the accept.
        flush = 1'b1; valid_in = 1'b1; op = 3'd0;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0;
        check("idle_flush_no_accept", ready_in, 1'b1);
        do_op(3'd0, 32'd3, 32'd4, 32'd12, 2);

        // Reset mid-divide with valid_in high.
        op = 3'd5; op_a = 32'd1000; op_b = 32'd3; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1; valid_in = 1'b1; op = 3'd0; op_a = 32'd5; op_b = 32'd5;
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_valid", valid_out, 1'b0);
            check("midrst_result", result, 32'h0);
            check("midrst_ready_in", ready_in, 1'b0);
        end
        rst = 1'b0; valid_in = 1'b0;
        #1;
        check("midrst_release_ready", ready_in, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_accept", valid_out, 1'b0);
            check("midrst_idle", ready_in, 1'b1);
        end

        // Randomized traffic; the per-cycle model does all checking here.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            valid_in  = $urandom_range(0, 1);
            ready_out = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            op_a      = pick();
            op_b      = pick();
            @(posedge clk); #1;
        end
        rst = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        check("drain_idle", ready_in, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
